counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 153 +++++++++++++++
 tb/tb_counter_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: drives an external up/down counter (load strobe, count
// enable, direction) from a simple command interface and reports completion
// with wrap/abort flags.
module counter_sequencer #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic             ld_en,
    output logic             en,
    output logic             updwn,
    output logic [WIDTH-1:0] datain,
    input  logic [WIDTH-1:0] dataout,
    output logic             resp_valid,
    output logic             resp_wrap,
    output logic             resp_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_HOLD,
        S_DONE
    } state_e;

    localparam logic [1:0]       OP_LOAD = 2'b00;
    localparam logic [1:0]       OP_DOWN = 2'b10;
    localparam logic [1:0]       OP_HOLD = 2'b11;
    localparam logic [WIDTH-1:0] MAXV    = '1;
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] datain_q, datain_d;
    logic             updwn_q, updwn_d;
    logic             wrap_q, wrap_d;
    logic             abort_q, abort_d;
    logic             rdy_q;
    logic             bound;
    logic             sat_stop;

    // Boundary seen this COUNT cycle: the next step would cross max/0.
    always_comb begin
        bound = 1'b0;
        if (state_q == S_COUNT) begin
            bound = updwn_q ? (dataout == ZERO) : (dataout == MAXV);
        end
        sat_stop = SATURATE && bound;
    end

    // Outputs decoded from registered state; only en sees abort/saturation live.
    always_comb begin
        cmd_ready  = rdy_q && (state_q == S_IDLE);
        ld_en      = (state_q == S_LOAD);
        en         = (state_q == S_COUNT) && !abort && !sat_stop;
        updwn      = updwn_q;
        datain     = datain_q;
        resp_valid = (state_q == S_DONE);
        resp_wrap  = (state_q == S_DONE) && wrap_q;
        resp_abort = (state_q == S_DONE) && abort_q;
    end

    // Next-state logic: command capture, step countdown, abort/wrap handling.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        datain_d = datain_q;
        updwn_d  = updwn_q;
        wrap_d   = wrap_q;
        abort_d  = abort_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    wrap_d  = 1'b0;
                    abort_d = 1'b0;
                    case (cmd_op)
                        OP_LOAD: begin
                            datain_d = cmd_arg;
                            state_d  = S_LOAD;
                        end
                        OP_HOLD: begin
                            rem_d   = cmd_arg;
                            state_d = (cmd_arg == ZERO) ? S_DONE : S_HOLD;
                        end
                        default: begin
                            rem_d   = cmd_arg;
                            updwn_d = (cmd_op == OP_DOWN);
                            state_d = (cmd_arg == ZERO) ? S_DONE : S_COUNT;
                        end
                    endcase
                end
            end
            S_LOAD: state_d = S_DONE;
            S_COUNT: begin
                wrap_d = wrap_q | bound;
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (sat_stop) begin
                    state_d = S_DONE;
                end else begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) state_d = S_DONE;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) state_d = S_DONE;
                end
            end
            S_DONE: begin
                wrap_d  = 1'b0;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and flag registers; rdy_q holds off cmd_ready until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            datain_q <= '0;
            updwn_q  <= 1'b0;
            wrap_q   <= 1'b0;
            abort_q  <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            datain_q <= datain_d;
            updwn_q  <= updwn_d;
            wrap_q   <= wrap_d;
            abort_q  <= abort_d;
            rdy_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: two instances (wrapping and saturating) share
// one command stream; each drives its own counter model. A schedule model
// turns every accepted command into a list of per-cycle expected outputs.
module tb_counter_sequencer;

    typedef struct packed {
        logic       ld, en, chk_ud, ud, rv, wr, ab, rdy;
        logic [7:0] din;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'h00;
    logic       abort = 1'b0;
    logic [1:0] cmd_ready_w, ld_en_w, en_w, updwn_w, rv_w, rw_w, ra_w;
    logic [7:0] din0, din1;
    logic [7:0] cnt0 = 8'h00;
    logic [7:0] cnt1 = 8'h00;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] mcnt [2];
    int         nchk = 0, nfail = 0, cyc = 0, acc = 0;
    int         en_tot [2], ld_tot [2], en_base [2], ld_base [2], resp_cyc [2];
    logic       rwr [2], rab [2];

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[0]),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .ld_en(ld_en_w[0]),
        .en(en_w[0]), .updwn(updwn_w[0]), .datain(din0), .dataout(cnt0),
        .resp_valid(rv_w[0]), .resp_wrap(rw_w[0]), .resp_abort(ra_w[0]));

    counter_sequencer #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[1]),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .ld_en(ld_en_w[1]),
        .en(en_w[1]), .updwn(updwn_w[1]), .datain(din1), .dataout(cnt1),
        .resp_valid(rv_w[1]), .resp_wrap(rw_w[1]), .resp_abort(ra_w[1]));

    // External counters driven by each sequencer.
    always @(posedge clk) begin
        if (ld_en_w[0]) cnt0 <= din0;
        else if (en_w[0]) cnt0 <= updwn_w[0] ? cnt0 - 8'd1 : cnt0 + 8'd1;
    end
    always @(posedge clk) begin
        if (ld_en_w[1]) cnt1 <= din1;
        else if (en_w[1]) cnt1 <= updwn_w[1] ? cnt1 - 8'd1 : cnt1 + 8'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        nchk++;
        if (act !== want) begin
            nfail++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, want);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Expected per-cycle outputs for one command, from counter value and rules.
    task automatic build(input int i, input bit sat, input logic [1:0] op,
                         input logic [7:0] n, input int abk);
        exp_t       e;
        logic [7:0] c;
        bit         wr, ab, dn, bnd;
        c  = mcnt[i];
        wr = 1'b0;
        ab = 1'b0;
        dn = (op == 2'b10);
        if (op == 2'b00) begin
            e = '0; e.ld = 1'b1; e.din = n;
            push(i, e);
            mcnt[i] = n;
        end else if (n != 8'h00) begin
            for (int k = 1; k <= int'(n); k++) begin
                e = '0;
                if (op != 2'b11) begin e.chk_ud = 1'b1; e.ud = dn; end
                bnd = (op != 2'b11) && (dn ? (c == 8'h00) : (c == 8'hFF));
                if (k == abk) begin
                    wr = wr | bnd; ab = 1'b1;
                    push(i, e);
                    break;
                end
                if (bnd) begin
                    wr = 1'b1;
                    if (sat) begin push(i, e); break; end
                end
                if (op != 2'b11) begin
                    e.en = 1'b1;
                    c = dn ? c - 8'd1 : c + 8'd1;
                end
                push(i, e);
            end
            mcnt[i] = c;
        end
        e = '0; e.rv = 1'b1; e.wr = wr; e.ab = ab;
        push(i, e);
    endtask

    task automatic compare_loop();
        exp_t        e;
        logic [7:0]  din;
        logic [16:0] act, want;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                din = (i == 0) ? din0 : din1;
                if (!rst_n) begin
                    chk($sformatf("reset_outputs_%0d", i),
                        {17'd0, cmd_ready_w[i], ld_en_w[i], en_w[i], updwn_w[i],
                         rv_w[i], rw_w[i], ra_w[i], din}, 32'd0);
                end else begin
                    e = '0; e.rdy = 1'b1;
                    if (i == 0 && q0.size() > 0) e = q0.pop_front();
                    else if (i == 1 && q1.size() > 0) e = q1.pop_front();
                    act  = {ld_en_w[i], en_w[i], e.chk_ud & updwn_w[i], rv_w[i], rw_w[i],
                            ra_w[i], cmd_ready_w[i], 2'b00, e.ld ? din : 8'h00};
                    want = {e.ld, e.en, e.chk_ud & e.ud, e.rv, e.wr, e.ab, e.rdy,
                            2'b00, e.din};
                    chk($sformatf("cycle_outputs_%0d", i), {15'd0, act}, {15'd0, want});
                    if (en_w[i]) en_tot[i]++;
                    if (ld_en_w[i]) ld_tot[i]++;
                    if (rv_w[i]) begin
                        resp_cyc[i] = cyc; rwr[i] = rw_w[i]; rab[i] = ra_w[i];
                    end
                end
            end
            cyc++;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) begin
            chk("response_timeout", 32'd1, 32'd0);
            q0.delete(); q1.delete();
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] n, input int abk);
        wait_idle();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = n;
        @(posedge clk);
        acc = cyc;
        for (int i = 0; i < 2; i++) begin
            en_base[i] = en_tot[i]; ld_base[i] = ld_tot[i];
        end
        build(0, 1'b0, op, n, abk);
        build(1, 1'b1, op, n, abk);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00;
        if (abk > 0) begin
            repeat (abk - 1) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 8'h00; en_tot[i] = 0; ld_tot[i] = 0; en_base[i] = 0;
            ld_base[i] = 0; resp_cyc[i] = 0; rwr[i] = 1'b0; rab[i] = 1'b0;
        end
        fork
            compare_loop();
        join_none
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // LOAD 5A
        do_cmd(2'b00, 8'h5A, 0); wait_idle();
        chk("load_dataout_wrap", cnt0, 8'h5A);
        chk("load_dataout_sat", cnt1, 8'h5A);
        chk("load_resp_latency", resp_cyc[0] - acc + 1, 2);
        chk("load_ld_cycles", ld_tot[0] - ld_base[0], 1);

        // LOAD 10, UP 5
        do_cmd(2'b00, 8'h10, 0); do_cmd(2'b01, 8'd5, 0); wait_idle();
        chk("up5_en_cycles", en_tot[0] - en_base[0], 5);
        chk("up5_dataout", cnt0, 8'h15);
        chk("up5_wrap", rwr[0], 1'b0);
        chk("up5_resp_latency", resp_cyc[0] - acc + 1, 6);

        // LOAD FE, UP 4 across the top boundary
        do_cmd(2'b00, 8'hFE, 0); do_cmd(2'b01, 8'd4, 0); wait_idle();
        chk("upwrap_en_cycles_wrap", en_tot[0] - en_base[0], 4);
        chk("upwrap_dataout_wrap", cnt0, 8'h02);
        chk("upwrap_flag_wrap", rwr[0], 1'b1);
        chk("upwrap_en_cycles_sat", en_tot[1] - en_base[1], 1);
        chk("upwrap_dataout_sat", cnt1, 8'hFF);
        chk("upwrap_flag_sat", rwr[1], 1'b1);

        // LOAD 01, DOWN 10 with abort on the 3rd COUNT cycle
        do_cmd(2'b00, 8'h01, 0); do_cmd(2'b10, 8'd10, 3); wait_idle();
        chk("dnabort_en_cycles", en_tot[0] - en_base[0], 2);
        chk("dnabort_dataout", cnt0, 8'hFF);
        chk("dnabort_wrap", rwr[0], 1'b1);
        chk("dnabort_abort", rab[0], 1'b1);
        chk("dnabort_dataout_sat", cnt1, 8'h00);
        chk("dnabort_abort_sat", rab[1], 1'b0);

        // DOWN N=0 and HOLD N=3
        do_cmd(2'b10, 8'd0, 0); wait_idle();
        chk("down0_resp_latency", resp_cyc[0] - acc + 1, 1);
        chk("down0_en_cycles", en_tot[0] - en_base[0], 0);
        do_cmd(2'b11, 8'd3, 0); wait_idle();
        chk("hold3_resp_latency", resp_cyc[0] - acc + 1, 4);
        chk("hold3_en_ld_cycles", (en_tot[0] - en_base[0]) + (ld_tot[0] - ld_base[0]), 0);

        // HOLD 5 aborted on its 2nd cycle
        do_cmd(2'b11, 8'd5, 2); wait_idle();
        chk("holdabort_resp_latency", resp_cyc[0] - acc + 1, 3);
        chk("holdabort_abort", rab[0], 1'b1);

        // LOAD 00, DOWN 2 across the bottom boundary
        do_cmd(2'b00, 8'h00, 0); do_cmd(2'b10, 8'd2, 0); wait_idle();
        chk("dnwrap_dataout_wrap", cnt0, 8'hFE);
        chk("dnwrap_dataout_sat", cnt1, 8'h00);
        chk("dnwrap_en_cycles_sat", en_tot[1] - en_base[1], 0);

        // Reset in the middle of a long UP
        do_cmd(2'b01, 8'd20, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {ld_en_w, en_w, rv_w, cmd_ready_w}, 8'h00);
        q0.delete(); q1.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", cmd_ready_w, 2'b11);
        do_cmd(2'b00, 8'h33, 0); wait_idle();
        chk("load_after_reset", cnt0, 8'h33);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
